rename_stage: RTL and testbench
===============================

# rename_stage

Register-rename stage directly downstream of the fetch/decode front end. It accepts one decoded instruction per cycle over a valid/ready handshake. It maps architectural sources and destination to physical registers through a register alias table (RAT) and a circular free list. It presents the renamed instruction to dispatch through a one-entry output register. Physical registers return to the free list through a commit-side release port.

## Interface
- NUM_PREGS, 64, physical register count (power of two, >32); PREG_W = $clog2(NUM_PREGS); FL_DEPTH = NUM_PREGS-32
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- fe_valid_i  input  1  decoded instruction valid
- fe_ready_o  output  1  stage can accept this cycle
- fe_pc_i, fe_imm_i  input  32 each  PC, immediate
- fe_rs1_i, fe_rs2_i, fe_rd_i  input  5 each  architectural registers
- fe_ALUSrc_i, fe_branch_i, fe_jump_i, fe_MemRead_i, fe_MemWrite_i, fe_RegWrite_i, fe_MemToReg_i  input  1 each  control
- fe_ALUOp_i  input  3  ALU op
- rel_valid_i  input  1  release one physical register (commit of an instruction's old mapping)
- rel_preg_i  input  PREG_W  register being released
- ren_valid_o  output  1  renamed instruction valid
- ren_ready_i  input  1  dispatch accepts
- ren_prs1_o, ren_prs2_o, ren_prd_o, ren_old_prd_o  output  PREG_W each  physical sources, new dest, previous dest mapping
- ren_pc_o, ren_imm_o, ren_ALUOp_o, ren_<control>_o  output  pass-through of registered inputs, same widths

## Operation
- RAT: 32 x PREG_W registers. Entry 0 is hard-wired to p0 and is never written.
- Free list: FL_DEPTH-entry circular buffer, head/tail pointers, count 0..FL_DEPTH. It pops at head and pushes at tail; pointers wrap at FL_DEPTH.
- needs_alloc = fe_RegWrite_i && fe_rd_i != 0.
- fe_ready_o = (!ren_valid_o || ren_ready_i) && (!needs_alloc || count != 0). It is purely combinational from current state and inputs.
- Accept = fe_valid_i && fe_ready_o. On accept, the output register loads:
  - prs1 = RAT[rs1], prs2 = RAT[rs2]
  - prd = needs_alloc ? free_list[head] : 0
  - old_prd = needs_alloc ? RAT[rd] : 0
  - all pass-through fields
- On accept with needs_alloc, RAT[rd] <= free_list[head], head++ and count--.
- RAT reads use pre-update contents. The prior accepted instruction's write is already visible, so back-to-back dependencies rename correctly. Same-instruction rs==rd reads the old mapping.
- Release: on rel_valid_i, free_list[tail] <= rel_preg_i, tail++ and count++. Release while count==FL_DEPTH is ignored (illegal; bench asserts it never occurs). rel_preg_i==0 is ignored.
- Simultaneous pop and push: count is unchanged and both pointers advance.
  - A released register is not available for allocation in the same cycle. The empty check uses the registered count.
- Output register: ren_valid_o <= accept ? 1 : (ren_ready_i ? 0 : ren_valid_o). Data holds stable while ren_valid_o && !ren_ready_i.
- No flush/recovery in this revision.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - RAT[i]=i
  - free_list[k]=32+k, head=0, tail=0, count=FL_DEPTH
  - ren_valid_o=0, all ren_* data outputs 0
- Latency: one cycle, from accept edge to ren_valid_o high.
- Throughput: one instruction per cycle while dispatch is ready and registers are free.
- Stall on empty free list blocks only instructions with needs_alloc. Stores, branches and rd=x0 pass.
- A release at edge N makes the register allocatable from cycle N+1.
- Reset mid-operation discards the output register contents and all allocations immediately.

## Test plan
- Reset, then issue add x1: rd=1, RegWrite -> ren_prd_o=32, ren_old_prd_o=1, ren_valid_o high 1 cycle after accept.
- Back-to-back add x1 then add x2,rs1=x1 -> second ren_prs1_o=32, ren_prd_o=33.
- Issue 32 RegWrite instructions with no release -> 33rd has fe_ready_o=0; a store (RegWrite=0) still accepted. rel_valid_i with preg 5 -> allocation resumes next cycle with prd=5.
- Hold ren_ready_i=0 for 3 cycles with fe_valid_i=1 -> fe_ready_o=0, outputs stable, no RAT/free-list change; accept resumes when ren_ready_i=1.
- rd=x0 with RegWrite=1 -> prd=0, old_prd=0, count unchanged. Simultaneous allocate+release at count=1 -> count stays 1, head and tail both advance.
- Assert reset mid-stream after 10 allocations -> ren_valid_o=0 at once; next add x3 gets prd=32, old_prd=3.

Source files
------------

// File: rtl/rename_stage.sv
// Register-rename stage: RAT lookup plus circular free-list allocation, with the
// renamed instruction held in a one-entry output register towards dispatch.
module rename_stage #(
  parameter  int NUM_PREGS = 64,
  localparam int PREG_W    = $clog2(NUM_PREGS),
  localparam int FL_DEPTH  = NUM_PREGS - 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fe_valid_i,
  output logic              fe_ready_o,
  input  logic [31:0]       fe_pc_i,
  input  logic [31:0]       fe_imm_i,
  input  logic [4:0]        fe_rs1_i,
  input  logic [4:0]        fe_rs2_i,
  input  logic [4:0]        fe_rd_i,
  input  logic              fe_ALUSrc_i,
  input  logic              fe_branch_i,
  input  logic              fe_jump_i,
  input  logic              fe_MemRead_i,
  input  logic              fe_MemWrite_i,
  input  logic              fe_RegWrite_i,
  input  logic              fe_MemToReg_i,
  input  logic [2:0]        fe_ALUOp_i,
  input  logic              rel_valid_i,
  input  logic [PREG_W-1:0] rel_preg_i,
  output logic              ren_valid_o,
  input  logic              ren_ready_i,
  output logic [PREG_W-1:0] ren_prs1_o,
  output logic [PREG_W-1:0] ren_prs2_o,
  output logic [PREG_W-1:0] ren_prd_o,
  output logic [PREG_W-1:0] ren_old_prd_o,
  output logic [31:0]       ren_pc_o,
  output logic [31:0]       ren_imm_o,
  output logic [2:0]        ren_ALUOp_o,
  output logic              ren_ALUSrc_o,
  output logic              ren_branch_o,
  output logic              ren_jump_o,
  output logic              ren_MemRead_o,
  output logic              ren_MemWrite_o,
  output logic              ren_RegWrite_o,
  output logic              ren_MemToReg_o
);
  localparam int PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int CNT_W = $clog2(FL_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FL_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FL_DEPTH);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [2:0]        alu_op;
    logic              alu_src;
    logic              branch;
    logic              jump;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
  } ren_t;

  logic [PREG_W-1:0] rat_q [32];
  logic [PREG_W-1:0] fl_q  [FL_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ren_valid_q, ren_valid_d;
  ren_t              ren_q, ren_d;
  logic              needs_alloc, accept, alloc, push;

  // Both ports use valid/ready: a transfer happens on a clock edge where valid
  // and ready are both high; valid never waits on ready, and ready here is a
  // pure function of registered state and current inputs.
  assign needs_alloc = fe_RegWrite_i && (fe_rd_i != 5'd0);
  assign fe_ready_o  = (!ren_valid_q || ren_ready_i) && (!needs_alloc || (count_q != '0));
  assign accept      = fe_valid_i && fe_ready_o;
  assign alloc       = accept && needs_alloc;
  assign push        = rel_valid_i && (rel_preg_i != '0) && (count_q != CNT_FULL);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alloc) head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
    if (push)  tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
    case ({alloc, push})
      2'b10:   count_d = count_q - 1'b1;
      2'b01:   count_d = count_q + 1'b1;
      default: count_d = count_q;
    endcase
  end

  // RAT reads see the contents before this cycle's allocation, so rs==rd
  // within one instruction picks up the old mapping.
  always_comb begin
    ren_d            = ren_q;
    ren_valid_d      = ren_valid_q;
    if (accept) begin
      ren_valid_d      = 1'b1;
      ren_d.pc         = fe_pc_i;
      ren_d.imm        = fe_imm_i;
      ren_d.alu_op     = fe_ALUOp_i;
      ren_d.alu_src    = fe_ALUSrc_i;
      ren_d.branch     = fe_branch_i;
      ren_d.jump       = fe_jump_i;
      ren_d.mem_read   = fe_MemRead_i;
      ren_d.mem_write  = fe_MemWrite_i;
      ren_d.reg_write  = fe_RegWrite_i;
      ren_d.mem_to_reg = fe_MemToReg_i;
      ren_d.prs1       = rat_q[fe_rs1_i];
      ren_d.prs2       = rat_q[fe_rs2_i];
      ren_d.prd        = needs_alloc ? fl_q[head_q]  : '0;
      ren_d.old_prd    = needs_alloc ? rat_q[fe_rd_i] : '0;
    end else if (ren_ready_i) begin
      ren_valid_d = 1'b0;
    end
  end

  // Entry 0 is loaded with p0 at reset and the write path never targets x0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rat_q[i] <= PREG_W'(i);
    end else if (alloc) begin
      rat_q[fe_rd_i] <= fl_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FL_DEPTH; k++) fl_q[k] <= PREG_W'(32 + k);
    end else if (push) begin
      fl_q[tail_q] <= rel_preg_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= CNT_FULL;
      ren_valid_q <= 1'b0;
      ren_q       <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ren_valid_q <= ren_valid_d;
      ren_q       <= ren_d;
    end
  end

  assign ren_valid_o    = ren_valid_q;
  assign ren_prs1_o     = ren_q.prs1;
  assign ren_prs2_o     = ren_q.prs2;
  assign ren_prd_o      = ren_q.prd;
  assign ren_old_prd_o  = ren_q.old_prd;
  assign ren_pc_o       = ren_q.pc;
  assign ren_imm_o      = ren_q.imm;
  assign ren_ALUOp_o    = ren_q.alu_op;
  assign ren_ALUSrc_o   = ren_q.alu_src;
  assign ren_branch_o   = ren_q.branch;
  assign ren_jump_o     = ren_q.jump;
  assign ren_MemRead_o  = ren_q.mem_read;
  assign ren_MemWrite_o = ren_q.mem_write;
  assign ren_RegWrite_o = ren_q.reg_write;
  assign ren_MemToReg_o = ren_q.mem_to_reg;
endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: hand-computed physical register numbers for
// allocation, dependencies, stalls, free-list exhaustion/release and reset.
module tb_rename_stage;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          fe_valid_i, fe_ready_o;
  logic [31:0]   fe_pc_i, fe_imm_i;
  logic [4:0]    fe_rs1_i, fe_rs2_i, fe_rd_i;
  logic          fe_ALUSrc_i, fe_branch_i, fe_jump_i, fe_MemRead_i;
  logic          fe_MemWrite_i, fe_RegWrite_i, fe_MemToReg_i;
  logic [2:0]    fe_ALUOp_i;
  logic          rel_valid_i;
  logic [PW-1:0] rel_preg_i;
  logic          ren_valid_o, ren_ready_i;
  logic [PW-1:0] ren_prs1_o, ren_prs2_o, ren_prd_o, ren_old_prd_o;
  logic [31:0]   ren_pc_o, ren_imm_o;
  logic [2:0]    ren_ALUOp_o;
  logic          ren_ALUSrc_o, ren_branch_o, ren_jump_o, ren_MemRead_o;
  logic          ren_MemWrite_o, ren_RegWrite_o, ren_MemToReg_o;

  int n_cmp = 0;
  int n_bad = 0;

  rename_stage #(.NUM_PREGS(64)) dut (
    .clk(clk), .reset(reset),
    .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o),
    .fe_pc_i(fe_pc_i), .fe_imm_i(fe_imm_i),
    .fe_rs1_i(fe_rs1_i), .fe_rs2_i(fe_rs2_i), .fe_rd_i(fe_rd_i),
    .fe_ALUSrc_i(fe_ALUSrc_i), .fe_branch_i(fe_branch_i), .fe_jump_i(fe_jump_i),
    .fe_MemRead_i(fe_MemRead_i), .fe_MemWrite_i(fe_MemWrite_i),
    .fe_RegWrite_i(fe_RegWrite_i), .fe_MemToReg_i(fe_MemToReg_i),
    .fe_ALUOp_i(fe_ALUOp_i),
    .rel_valid_i(rel_valid_i), .rel_preg_i(rel_preg_i),
    .ren_valid_o(ren_valid_o), .ren_ready_i(ren_ready_i),
    .ren_prs1_o(ren_prs1_o), .ren_prs2_o(ren_prs2_o),
    .ren_prd_o(ren_prd_o), .ren_old_prd_o(ren_old_prd_o),
    .ren_pc_o(ren_pc_o), .ren_imm_o(ren_imm_o), .ren_ALUOp_o(ren_ALUOp_o),
    .ren_ALUSrc_o(ren_ALUSrc_o), .ren_branch_o(ren_branch_o), .ren_jump_o(ren_jump_o),
    .ren_MemRead_o(ren_MemRead_o), .ren_MemWrite_o(ren_MemWrite_o),
    .ren_RegWrite_o(ren_RegWrite_o), .ren_MemToReg_o(ren_MemToReg_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fe_valid_i = 1'b0;
    rel_valid_i = 1'b0;
    ren_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // drivers
  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic rw, input logic mw, input logic [2:0] op);
    fe_valid_i    = 1'b1;
    fe_pc_i       = pc;
    fe_imm_i      = pc ^ 32'h5A5A_0000;
    fe_rs1_i      = rs1;
    fe_rs2_i      = rs2;
    fe_rd_i       = rd;
    fe_RegWrite_i = rw;
    fe_MemWrite_i = mw;
    fe_ALUSrc_i   = mw;
    fe_MemRead_i  = 1'b0;
    fe_MemToReg_i = 1'b0;
    fe_branch_i   = 1'b0;
    fe_jump_i     = 1'b0;
    fe_ALUOp_i    = op;
  endtask

  task automatic idle();
    fe_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++; if (ren_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", ren_valid_o); end
    n_cmp++; if (ren_prd_o !== 6'd0) begin n_bad++; $display("FAIL reset_prd: got %0d want 0", ren_prd_o); end
    n_cmp++; if (ren_pc_o !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", ren_pc_o); end
    do_reset();
    set_instr(32'h100, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 3'd3);
    #1;
    n_cmp++; if (fe_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", fe_ready_o); end
    n_cmp++; if (ren_valid_o !== 1'b0) begin n_bad++; $display("FAIL pre_accept_valid: got %0b want 0", ren_valid_o); end
  endtask

  task automatic test_single_add();
    tick();
    n_cmp++; if (ren_valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0b want 1", ren_valid_o); end
    n_cmp++; if (ren_prd_o !== 6'd32) begin n_bad++; $display("FAIL single_prd: got %0d want 32", ren_prd_o); end
    n_cmp++; if (ren_old_prd_o !== 6'd1) begin n_bad++; $display("FAIL single_old: got %0d want 1", ren_old_prd_o); end
    n_cmp++; if (ren_pc_o !== 32'h100) begin n_bad++; $display("FAIL single_pc: got %h want 100", ren_pc_o); end
    n_cmp++; if (ren_imm_o !== 32'h5A5A_0100) begin n_bad++; $display("FAIL single_imm: got %h want 5a5a0100", ren_imm_o); end
    n_cmp++; if (ren_ALUOp_o !== 3'd3) begin n_bad++; $display("FAIL single_aluop: got %0d want 3", ren_ALUOp_o); end
    n_cmp++; if (ren_RegWrite_o !== 1'b1) begin n_bad++; $display("FAIL single_regwrite: got %0b want 1", ren_RegWrite_o); end
    idle();
    tick();
    n_cmp++; if (ren_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %0b want 0", ren_valid_o); end
  endtask

  task automatic test_back_to_back();
    set_instr(32'h104, 5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 3'd0);
    tick();
    n_cmp++; if (ren_prs1_o !== 6'd32) begin n_bad++; $display("FAIL b2b_prs1: got %0d want 32", ren_prs1_o); end
    n_cmp++; if (ren_prs2_o !== 6'd2) begin n_bad++; $display("FAIL b2b_prs2: got %0d want 2", ren_prs2_o); end
    n_cmp++; if (ren_prd_o !== 6'd33) begin n_bad++; $display("FAIL b2b_prd: got %0d want 33", ren_prd_o); end
    set_instr(32'h108, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 3'd1);
    tick();
    n_cmp++; if (ren_prs1_o !== 6'd33) begin n_bad++; $display("FAIL b2b_dep_prs1: got %0d want 33", ren_prs1_o); end
    n_cmp++; if (ren_prd_o !== 6'd34) begin n_bad++; $display("FAIL b2b_dep_prd: got %0d want 34", ren_prd_o); end
    n_cmp++; if (ren_old_prd_o !== 6'd3) begin n_bad++; $display("FAIL b2b_dep_old: got %0d want 3", ren_old_prd_o); end
    idle();
    tick();
  endtask

  task automatic test_rd_zero_and_self_dep();
    set_instr(32'h10C, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 3'd2);
    tick();
    n_cmp++; if (ren_prd_o !== 6'd0) begin n_bad++; $display("FAIL x0_prd: got %0d want 0", ren_prd_o); end
    n_cmp++; if (ren_old_prd_o !== 6'd0) begin n_bad++; $display("FAIL x0_old: got %0d want 0", ren_old_prd_o); end
    n_cmp++; if (ren_prs1_o !== 6'd34) begin n_bad++; $display("FAIL x0_prs1: got %0d want 34", ren_prs1_o); end
    set_instr(32'h110, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 3'd0);
    tick();
    n_cmp++; if (ren_prs1_o !== 6'd34) begin n_bad++; $display("FAIL self_prs1: got %0d want 34", ren_prs1_o); end
    n_cmp++; if (ren_prd_o !== 6'd35) begin n_bad++; $display("FAIL self_prd: got %0d want 35", ren_prd_o); end
    n_cmp++; if (ren_old_prd_o !== 6'd34) begin n_bad++; $display("FAIL self_old: got %0d want 34", ren_old_prd_o); end
    idle();
    tick();
  endtask

  task automatic test_stall();
    set_instr(32'h200, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 3'd4);
    tick();
    ren_ready_i = 1'b0;
    set_instr(32'h204, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 3'd5);
    #1;
    n_cmp++; if (fe_ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %0b want 0", fe_ready_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (ren_valid_o !== 1'b1 || ren_prd_o !== 6'd36 || ren_pc_o !== 32'h200) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v=%0b prd=%0d pc=%h want v=1 prd=36 pc=200", c, ren_valid_o, ren_prd_o, ren_pc_o);
      end
    end
    ren_ready_i = 1'b1;
    #1;
    n_cmp++; if (fe_ready_o !== 1'b1) begin n_bad++; $display("FAIL stall_resume_ready: got %0b want 1", fe_ready_o); end
    tick();
    n_cmp++; if (ren_prd_o !== 6'd37) begin n_bad++; $display("FAIL stall_resume_prd: got %0d want 37", ren_prd_o); end
    n_cmp++; if (ren_prs1_o !== 6'd36) begin n_bad++; $display("FAIL stall_resume_prs1: got %0d want 36", ren_prs1_o); end
    n_cmp++; if (ren_old_prd_o !== 6'd5) begin n_bad++; $display("FAIL stall_resume_old: got %0d want 5", ren_old_prd_o); end
    idle();
    tick();
  endtask

  task automatic test_exhaust_release();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_instr(32'h300 + 32'(4 * i), 5'd0, 5'd0, 5'(1 + (i % 31)), 1'b1, 1'b0, 3'd0);
      tick();
      n_cmp++; if (ren_prd_o !== 6'(32 + i)) begin n_bad++; $display("FAIL exh_prd[%0d]: got %0d want %0d", i, ren_prd_o, 32 + i); end
    end
    n_cmp++; if (ren_old_prd_o !== 6'd32) begin n_bad++; $display("FAIL exh_last_old: got %0d want 32", ren_old_prd_o); end
    set_instr(32'h400, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 3'd0);
    #1;
    n_cmp++; if (fe_ready_o !== 1'b0) begin n_bad++; $display("FAIL exh_blocked: got %0b want 0", fe_ready_o); end
    tick();
    n_cmp++; if (ren_valid_o !== 1'b0) begin n_bad++; $display("FAIL exh_no_accept: got %0b want 0", ren_valid_o); end
    set_instr(32'h404, 5'd1, 5'd2, 5'd9, 1'b0, 1'b1, 3'd6);
    #1;
    n_cmp++; if (fe_ready_o !== 1'b1) begin n_bad++; $display("FAIL store_ready: got %0b want 1", fe_ready_o); end
    tick();
    n_cmp++; if (ren_valid_o !== 1'b1 || ren_prd_o !== 6'd0 || ren_old_prd_o !== 6'd0) begin
      n_bad++; $display("FAIL store_out: got v=%0b prd=%0d old=%0d want v=1 prd=0 old=0", ren_valid_o, ren_prd_o, ren_old_prd_o);
    end
    n_cmp++; if (ren_prs1_o !== 6'd63 || ren_prs2_o !== 6'd33) begin
      n_bad++; $display("FAIL store_srcs: got %0d,%0d want 63,33", ren_prs1_o, ren_prs2_o);
    end
    n_cmp++; if (ren_MemWrite_o !== 1'b1 || ren_ALUSrc_o !== 1'b1) begin n_bad++; $display("FAIL store_ctrl: got mw=%0b src=%0b want 1,1", ren_MemWrite_o, ren_ALUSrc_o); end
    set_instr(32'h408, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 3'd0);
    #1;
    n_cmp++; if (fe_ready_o !== 1'b1) begin n_bad++; $display("FAIL empty_x0_ready: got %0b want 1", fe_ready_o); end
    tick();
    set_instr(32'h40C, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 3'd0);
    rel_valid_i = 1'b1;
    rel_preg_i  = 6'd5;
    #1;
    n_cmp++; if (fe_ready_o !== 1'b0) begin n_bad++; $display("FAIL rel_same_cycle: got %0b want 0", fe_ready_o); end
    tick();
    rel_valid_i = 1'b0;
    #1;
    n_cmp++; if (fe_ready_o !== 1'b1) begin n_bad++; $display("FAIL rel_next_ready: got %0b want 1", fe_ready_o); end
    tick();
    n_cmp++; if (ren_prd_o !== 6'd5) begin n_bad++; $display("FAIL rel_prd: got %0d want 5", ren_prd_o); end
    n_cmp++; if (ren_old_prd_o !== 6'd38 || ren_prs1_o !== 6'd38) begin
      n_bad++; $display("FAIL rel_old: got old=%0d prs1=%0d want 38,38", ren_old_prd_o, ren_prs1_o);
    end
    idle();
    tick();
  endtask

  task automatic test_simul_alloc_release();
    rel_valid_i = 1'b1;
    rel_preg_i  = 6'd40;
    tick();
    set_instr(32'h500, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 3'd0);
    rel_preg_i = 6'd41;
    #1;
    n_cmp++; if (fe_ready_o !== 1'b1) begin n_bad++; $display("FAIL simul_ready: got %0b want 1", fe_ready_o); end
    tick();
    rel_valid_i = 1'b0;
    n_cmp++; if (ren_prd_o !== 6'd40) begin n_bad++; $display("FAIL simul_prd: got %0d want 40", ren_prd_o); end
    set_instr(32'h504, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 3'd0);
    #1;
    n_cmp++; if (fe_ready_o !== 1'b1) begin n_bad++; $display("FAIL simul_count_kept: got %0b want 1", fe_ready_o); end
    tick();
    n_cmp++; if (ren_prd_o !== 6'd41 || ren_prs1_o !== 6'd40) begin
      n_bad++; $display("FAIL simul_tail: got prd=%0d prs1=%0d want 41,40", ren_prd_o, ren_prs1_o);
    end
    set_instr(32'h508, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 3'd0);
    #1;
    n_cmp++; if (fe_ready_o !== 1'b0) begin n_bad++; $display("FAIL simul_empty: got %0b want 0", fe_ready_o); end
    rel_valid_i = 1'b1;
    rel_preg_i  = 6'd0;
    tick();
    rel_valid_i = 1'b0;
    #1;
    n_cmp++; if (fe_ready_o !== 1'b0) begin n_bad++; $display("FAIL rel_p0_ignored: got %0b want 0", fe_ready_o); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_instr(32'h600 + 32'(4 * i), 5'd0, 5'd0, 5'(1 + i), 1'b1, 1'b0, 3'd0);
      tick();
    end
    n_cmp++; if (ren_prd_o !== 6'd41 || ren_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL mid_tenth: got prd=%0d v=%0b want 41,1", ren_prd_o, ren_valid_o);
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (ren_valid_o !== 1'b0 || ren_prd_o !== 6'd0) begin
      n_bad++; $display("FAIL mid_async: got v=%0b prd=%0d want 0,0", ren_valid_o, ren_prd_o);
    end
    @(negedge clk);
    reset = 1'b0;
    set_instr(32'h700, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    n_cmp++; if (ren_prd_o !== 6'd32 || ren_old_prd_o !== 6'd3 || ren_prs1_o !== 6'd3) begin
      n_bad++; $display("FAIL mid_after: got prd=%0d old=%0d prs1=%0d want 32,3,3", ren_prd_o, ren_old_prd_o, ren_prs1_o);
    end
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    ren_ready_i = 1'b1;
    rel_valid_i = 1'b0;
    rel_preg_i = '0;
    set_instr(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0);
    idle();
    test_reset();
    test_single_add();
    test_back_to_back();
    test_rd_zero_and_self_dep();
    test_stall();
    test_exhaust_release();
    test_simul_alloc_release();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
